// File: rtl/data_mem_resp_pkg.sv
// Shared types for the data-memory responder: access size encoding, FSM state
// and the lane helpers used for byte-enable stores and extended loads.
package pkgs;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dm_state_t;

    // Encoding 2'b10 is unused by mem_access_size_t and is treated as illegal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a_lo);
        logic bad;
        case (size)
            BYTE:      bad = 1'b0;
            HALF_WORD: bad = a_lo[0];
            WORD:      bad = (a_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a_lo);
        logic [3:0] be;
        case (size)
            BYTE:      be = 4'b0001 << a_lo;
            HALF_WORD: be = a_lo[1] ? 4'b1100 : 4'b0011;
            WORD:      be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        case (size)
            BYTE:      r = {4{wd[7:0]}};
            HALF_WORD: r = {2{wd[15:0]}};
            default:   r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] a_lo,
                                                 input logic zext, input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {a_lo, 3'b000};
        case (size)
            BYTE:      r = {{24{~zext & sh[7]}}, sh[7:0]};
            HALF_WORD: r = {{16{~zext & sh[15]}}, sh[15:0]};
            default:   r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_resp_dm_sram.sv
// Single-port word memory with per-byte write enables and combinational read.
// Contents are deliberately not reset.
module dm_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one access in IDLE, waits WAIT_STATES cycles,
// then gives a one-cycle response. Handshake: request accepted on a rising edge with req && gnt.
module data_mem_resp
    import pkgs::*;
#(
    parameter int ADDR_W      = 19,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_byte_i,
    input  logic              zero_extnd_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [31:0]       data_rdata_o,
    output logic              data_err_o
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    dm_state_t state, state_nxt;
    logic [3:0] cnt;

    logic              wr_q, zext_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              cur_wr, cur_zext, cur_err;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;

    logic        accept, enter_resp, mem_we;
    logic [31:0] mem_rdata, rdata_q;
    logic        err_q;
    logic        unused_addr;

    assign accept = data_req_i && (state == IDLE) && rst_n;

    // With zero wait states the access completes on its own accept edge, so the
    // live inputs are used until the latched copy exists.
    always_comb begin
        cur_wr    = wr_q;
        cur_size  = size_q;
        cur_zext  = zext_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_wr    = data_wr_i;
            cur_size  = data_byte_i;
            cur_zext  = zero_extnd_i;
            cur_addr  = data_addr_i;
            cur_wdata = data_wdata_i;
        end
    end

    assign cur_err     = is_misaligned(cur_size, cur_addr[1:0]);
    assign enter_resp  = (state_nxt == RESP) && (state != RESP);
    assign mem_we      = enter_resp && cur_wr && !cur_err && rst_n;
    assign unused_addr = ^cur_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (WS_CNT != 4'd0) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_gnt_o    = (state == IDLE);
        data_rvalid_o = (state == RESP);
        data_rdata_o  = data_rvalid_o ? rdata_q : 32'h0;
        data_err_o    = data_rvalid_o ? err_q : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            zext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            if (accept) begin
                cnt     <= WS_CNT;
                wr_q    <= data_wr_i;
                size_q  <= data_byte_i;
                zext_q  <= zero_extnd_i;
                addr_q  <= data_addr_i;
                wdata_q <= data_wdata_i;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Response captured on the edge entering RESP; loads see pre-edge memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            err_q   <= cur_err;
            rdata_q <= (cur_err || cur_wr) ? 32'h0
                     : load_extract(cur_size, cur_addr[1:0], cur_zext, mem_rdata);
        end
    end

    dm_sram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_sram (
        .clk  (clk),
        .we   (mem_we),
        .be   (byte_en(cur_size, cur_addr[1:0])),
        .addr (cur_addr[IDX_W+1:2]),
        .wdata(lane_wdata(cur_size, cur_wdata)),
        .rdata(mem_rdata)
    );

endmodule
